// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types and constants for the CIM job sequencer
package cim_pkg;

  localparam int CIM_NOUT_MAX   = 16;
  localparam int IDX_W          = $clog2(CIM_NOUT_MAX);
  localparam int CIM_ADDR_MAX_W = 32;
  localparam int CIM_DATA_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_SETTLE,
    ST_DRAIN_REQ,
    ST_DRAIN_WAIT,
    ST_OUT,
    ST_DONE
  } state_e;

  // Address/data fields are sized for the widest supported macro; narrower tops slice them.
  typedef struct packed {
    logic                      we;
    logic                      cime;
    logic                      partial_sum_e;
    logic                      reset_output_reg;
    logic [IDX_W-1:0]          output_reg;
    logic [CIM_ADDR_MAX_W-1:0] address;
    logic [CIM_DATA_MAX_W-1:0] input_data;
  } cim_cmd_t;

endpackage

// File: rtl/cim_rd_delay.sv
// rtl/cim_rd_delay.sv - RD_LAT-deep valid shift register timing the cim_output capture
module cim_rd_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid
);

  logic [RD_LAT-1:0] sr_q;
  logic [RD_LAT-1:0] sr_d;

  generate
    if (RD_LAT == 1) begin : g_one
      always_comb begin
        sr_d = in_valid;
      end
    end else begin : g_multi
      always_comb begin
        sr_d = {sr_q[RD_LAT-2:0], in_valid};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_valid = sr_q[RD_LAT-1];

endmodule

// File: rtl/cim_job_sequencer.sv
// rtl/cim_job_sequencer.sv - sequences clear/compute/accumulate/drain on the GeMM CIM macro
module cim_job_sequencer
  import cim_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESN,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [7:0]        cfg_steps,
  input  logic [3:0]        cfg_nout,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [DATA_W-1:0] host_input_data,
  input  logic [DATA_W-1:0] cim_output,
  output logic              we,
  output logic              cime,
  output logic              partial_sum_e,
  output logic              reset_output_reg,
  output logic [3:0]        output_reg,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] input_data
);

  state_e            state_q, state_d;
  logic [7:0]        step_q, step_d;
  logic [7:0]        steps_q, steps_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        nout_q, nout_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] result_q, result_d;
  cim_cmd_t          cmd_q, cmd_d;

  logic in_fire;
  logic out_fire;
  logic drain_req;
  logic rd_vld;

  assign in_fire   = in_valid && (state_q == ST_FEED);
  assign out_fire  = out_ready && (state_q == ST_OUT);
  assign drain_req = (state_q == ST_DRAIN_REQ);

  cim_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
    .clk       (CLK),
    .rst_n     (RESN),
    .in_valid  (drain_req),
    .out_valid (rd_vld)
  );

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      steps_q  <= '0;
      idx_q    <= '0;
      nout_q   <= '0;
      base_q   <= '0;
      result_q <= '0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      steps_q  <= steps_d;
      idx_q    <= idx_d;
      nout_q   <= nout_d;
      base_q   <= base_d;
      result_q <= result_d;
      cmd_q    <= cmd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    steps_d  = steps_q;
    idx_d    = idx_q;
    nout_d   = nout_q;
    base_d   = base_q;
    result_d = result_q;
    cmd_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = cfg_base;
          steps_d = cfg_steps;
          nout_d  = cfg_nout;
          step_d  = '0;
          idx_d   = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR:        state_d = (steps_q == 8'd0) ? ST_DONE : ST_FEED;
      ST_FEED: begin
        if (in_fire) begin
          step_d = step_q + 8'd1;
          if (step_d == steps_q) state_d = ST_SETTLE;
        end
      end
      ST_SETTLE:     state_d = ST_DRAIN_REQ;
      ST_DRAIN_REQ:  state_d = ST_DRAIN_WAIT;
      ST_DRAIN_WAIT: begin
        if (rd_vld) begin
          result_d = cim_output;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_fire) begin
          if (idx_q == nout_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_DRAIN_REQ;
          end
        end
      end
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    // Macro commands are registered so each pin changes exactly one cycle after its cause.
    cmd_d.reset_output_reg = (state_d == ST_CLR);
    if (in_fire) begin
      cmd_d.cime          = 1'b1;
      cmd_d.partial_sum_e = (step_q != 8'd0);
      cmd_d.address       = CIM_ADDR_MAX_W'(base_q + ADDR_W'(step_q));
      cmd_d.input_data    = CIM_DATA_MAX_W'(in_data);
    end
    if ((state_d == ST_DRAIN_REQ) || (state_d == ST_DRAIN_WAIT)) begin
      cmd_d.output_reg = idx_d;
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    in_ready  = (state_q == ST_FEED);
    out_valid = (state_q == ST_OUT);
    out_last  = (state_q == ST_OUT) && (idx_q == nout_q);
    out_data  = result_q;
    done      = (state_q == ST_DONE);
    // While idle the host weight-write path owns the macro pins.
    if (state_q == ST_IDLE) begin
      we               = host_we;
      address          = host_address;
      input_data       = host_input_data;
      cime             = 1'b0;
      partial_sum_e    = 1'b0;
      reset_output_reg = 1'b0;
      output_reg       = '0;
    end else begin
      we               = cmd_q.we;
      address          = cmd_q.address[ADDR_W-1:0];
      input_data       = cmd_q.input_data[DATA_W-1:0];
      cime             = cmd_q.cime;
      partial_sum_e    = cmd_q.partial_sum_e;
      reset_output_reg = cmd_q.reset_output_reg;
      output_reg       = cmd_q.output_reg;
    end
  end

endmodule

// File: doc/cim_job_sequencer.md
# cim_job_sequencer

Hardware job sequencer between the darkriscv core and the `Basic_GeMM_CIM` macro. It takes a job descriptor and a stream of input vectors, issues the clear, compute and partial-sum-accumulate command sequence on the CIM control pins, then drains the selected output registers into a valid/ready result stream. The core then only queues vectors and collects results, and no longer bit-bangs `cime`, `partial_sum_e` and `output_reg`. While the sequencer is idle, host weight-write traffic passes straight through to the macro.

## Interface
Parameters:
- `ADDR_W`, 32, CIM address width.
- `DATA_W`, 32, input vector / result width.
- `RD_LAT`, 1, cycles from `output_reg` driven to `cim_output` valid. Legal values are 1 and 2.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESN` in 1: asynchronous, active-low reset.
- `start` in 1: job launch pulse, sampled only in IDLE.
- `cfg_base` in ADDR_W: CIM address of the first weight block.
- `cfg_steps` in 8: K, the number of input vectors (partial-sum steps).
- `cfg_nout` in 4: the number of output registers drained is `cfg_nout+1`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DATA_W: input vector stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_W, `out_last` out 1: result stream.
- `busy` out 1, `done` out 1: status; `done` is a one-cycle pulse.
- `host_we` in 1, `host_address` in ADDR_W, `host_input_data` in DATA_W: weight-load bypass path.
- `cim_output` in DATA_W: data from the macro.
- `we`, `cime`, `partial_sum_e`, `reset_output_reg` out 1 each; `output_reg` out 4; `address` out ADDR_W; `input_data` out DATA_W: drive the macro.

## Operation
- The descriptor (`cfg_*`) is latched on `start` in IDLE. Later changes to `cfg_*` have no effect on the running job.
- FSM states: IDLE → CLR → FEED → SETTLE → DRAIN_REQ → DRAIN_WAIT → OUT → DONE → IDLE.
  - **IDLE:** the CIM pins mirror the host path: `we=host_we`, `address=host_address`, `input_data=host_input_data`. All other CIM controls are 0. `busy=0`.
  - **CLR:** `reset_output_reg=1` for one cycle.
  - **FEED:** `in_ready=1`. On each handshake:
    - register `cime=1`, `input_data=in_data`, `address=cfg_base+step` (modulo 2^ADDR_W), and `partial_sum_e=(step!=0)`;
    - increment `step`.
    - After the K-th handshake the FSM moves to SETTLE.
  - **SETTLE:** one cycle for the final `cime` to complete.
  - **DRAIN_REQ:** drive `output_reg=idx`.
  - **DRAIN_WAIT:** wait `RD_LAT` cycles, then capture `cim_output` into the result register.
  - **OUT:** hold `out_valid=1` and `out_data`; `out_last=(idx==nout)`. On handshake:
    - if `idx==nout`, go to DONE;
    - otherwise `idx++` and return to DRAIN_REQ.
  - **DONE:** `done=1` for one cycle, then IDLE.
- K=0: the FSM goes IDLE → CLR → DONE. No `cime` is issued and no result beats are produced.
- `we` is 0 in every state except IDLE.
- `start` while busy is ignored.

## Timing
- Reset values (asynchronous, immediate on RESN low): all outputs 0, state IDLE, `step=0`, `idx=0`.
- `start` high in cycle 0 (IDLE) gives `busy=1` and `reset_output_reg=1` in cycle 1. FEED, with `in_ready=1`, begins in cycle 2.
- All CIM outputs are registered, except the combinational IDLE bypass.
- An input handshake in cycle t gives `cime=1` in cycle t+1, for exactly one cycle.
- Back-to-back input handshakes are allowed, one per cycle.
- `in_ready` is combinational from state only. It never depends on `in_valid`.
- Once `out_valid` is asserted it holds, with `out_data` stable, until `out_ready`. `out_valid` never depends on `out_ready`.
- Minimum drain cost per result is `2+RD_LAT` cycles.
- A minimal K=1, nout=0 job with both streams always ready has:
  - `done` at cycle `6+RD_LAT` after `start`;
  - `busy` falling the following cycle.
- RESN asserted mid-job: the job is abandoned and no `done` is issued. The macro's contents are untouched, but its output registers are stale; the next job's CLR resets them.

## Structure
- A shared package `cim_pkg` holds:
  - the FSM state enum;
  - the CIM command-bundle struct (`we`, `cime`, `partial_sum_e`, `reset_output_reg`, `output_reg`, `address`, `input_data`);
  - the `CIM_NOUT_MAX=16` constant.
- One sub-module, `cim_rd_delay`: an `RD_LAT`-deep valid shift register that times the `cim_output` capture.
- Everything else is flat.

## Test plan
- **Host bypass:** idle, `host_we=1`, `host_address=0x10`, `host_input_data=0xA5A5A5A5` → same values appear on `we`, `address` and `input_data` in the same cycle; `busy=0`.
- **Compute sequence:** `cfg_base=0x40`, K=3, inputs 0x1, 0x2, 0x3 back-to-back →
  - `reset_output_reg` pulses once;
  - `cime` pulses 3 times with addresses 0x40, 0x41, 0x42;
  - `partial_sum_e` reads 0, 1, 1;
  - `input_data` reads 0x1, 0x2, 0x3.
- **Drain with backpressure:** stub macro returns `cim_output=0x100+output_reg`; `nout=3`; `out_ready` low for 5 cycles on the 2nd beat →
  - results 0x100, 0x101, 0x102, 0x103 in order;
  - `out_data` stable while stalled;
  - `out_last` on the 4th beat only;
  - a single `done` pulse.
- **K=0:** `start` with `cfg_steps=0` → `reset_output_reg` pulse, `done` 2 cycles after `start`, no `cime`, no `out_valid`.
- **Wrap and config latch:**
  - `cfg_base=0xFFFFFFFF`, K=2 → addresses 0xFFFFFFFF then 0x0;
  - changing `cfg_*` mid-job has no effect;
  - a second `start` during the job is ignored.
- **Mid-job reset:** RESN low during FEED after 1 of 4 handshakes → all outputs 0 immediately; after release, a fresh K=1 job completes normally.
